// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: Avalon-MM input PIO with synchroniser, per-channel debounce,
// selectable edge capture (write-1-to-clear) and a masked level interrupt.
module pio_in_edge_irq #(
   parameter int          WIDTH       = 4,
   parameter int          SYNC_STAGES = 2,
   parameter int          DB_W        = 16,
   parameter int unsigned DB_RESET    = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);
   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [WIDTH-1:0] r_deb, r_deb_d, r_cap, r_mask, r_rise_en, r_fall_en;
   logic [DB_W-1:0]  r_cnt [WIDTH];
   logic [DB_W-1:0]  r_thresh;
   logic [WIDTH-1:0] w_sync, w_ev, w_clr, w_acc;
   logic [31:0]      w_rd;
   logic             w_wr;
   logic             w_unused;

   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_wr     = chipselect & ~write_n;
   assign w_ev     = (r_deb & ~r_deb_d & r_rise_en) | (~r_deb & r_deb_d & r_fall_en);
   assign w_clr    = (w_wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
   assign irq      = |(r_cap & r_mask);
   assign w_unused = &{1'b0, writedata};

   // Widened by one bit so the accept test can never overflow at the counter's top value.
   always_comb begin
      w_acc = '0;
      for (int i = 0; i < WIDTH; i++)
         w_acc[i] = ({1'b0, r_cnt[i]} + (DB_W+1)'(1)) >= {1'b0, r_thresh};
   end

   always_comb begin
      w_rd = '0;
      case (address)
         3'd0:    w_rd = 32'(r_deb);
         3'd1:    w_rd = 32'(w_sync);
         3'd2:    w_rd = 32'(r_mask);
         3'd3:    w_rd = 32'(r_cap);
         3'd4:    w_rd = 32'(r_rise_en);
         3'd5:    w_rd = 32'(r_fall_en);
         3'd6:    w_rd = 32'(r_thresh);
         default: w_rd = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
         r_deb     <= '0;
         r_deb_d   <= '0;
         r_cap     <= '0;
         r_mask    <= '0;
         r_rise_en <= '1;
         r_fall_en <= '1;
         r_thresh  <= DB_W'(DB_RESET);
         readdata  <= '0;
      end else begin
         r_sync[0] <= in_port;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
         for (int i = 0; i < WIDTH; i++) begin
            if (w_sync[i] == r_deb[i]) r_cnt[i] <= '0;
            else if (w_acc[i]) begin
               r_deb[i] <= w_sync[i];
               r_cnt[i] <= '0;
            end else r_cnt[i] <= r_cnt[i] + DB_W'(1);
         end
         r_deb_d  <= r_deb;
         // A new event outranks a simultaneous clear so no edge is ever lost.
         r_cap    <= (r_cap & ~w_clr) | w_ev;
         readdata <= w_rd;
         if (w_wr && address == 3'd2) r_mask    <= writedata[WIDTH-1:0];
         if (w_wr && address == 3'd4) r_rise_en <= writedata[WIDTH-1:0];
         if (w_wr && address == 3'd5) r_fall_en <= writedata[WIDTH-1:0];
         if (w_wr && address == 3'd6) r_thresh  <= writedata[DB_W-1:0];
      end
   end
endmodule

// File: tb/tb_pio_in_edge_irq.sv
// tb_pio_in_edge_irq: register-map vector table plus directed debounce, edge,
// capture-priority and reset sequences for pio_in_edge_irq (WIDTH=4, N reset 0).
module tb_pio_in_edge_irq;
   localparam int W = 4;
   logic          clk = 0, reset_n = 0;
   logic [2:0]    address = 0;
   logic          chipselect = 0, write_n = 1;
   logic [31:0]   writedata = 0;
   logic [31:0]   readdata;
   logic [W-1:0]  in_port = 0;
   logic          irq;
   logic [31:0]   rd;
   int            errs = 0, checks = 0;

   typedef struct {
      logic        wr;
      logic [2:0]  a;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[19];

   pio_in_edge_irq #(.WIDTH(W), .SYNC_STAGES(2), .DB_W(16), .DB_RESET(0)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1; write_n = 0; address = a; writedata = d;
      @(negedge clk);
      chipselect = 0; write_n = 1; address = 0; writedata = 0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      address = a;
      @(negedge clk);
      d = readdata;
      address = 0;
   endtask

   initial begin
      tbl[0]  = '{1'b0, 3'd0, 32'h0, 32'h0};
      tbl[1]  = '{1'b0, 3'd1, 32'h0, 32'h0};
      tbl[2]  = '{1'b0, 3'd2, 32'h0, 32'h0};
      tbl[3]  = '{1'b0, 3'd3, 32'h0, 32'h0};
      tbl[4]  = '{1'b0, 3'd4, 32'h0, 32'hF};
      tbl[5]  = '{1'b0, 3'd5, 32'h0, 32'hF};
      tbl[6]  = '{1'b0, 3'd6, 32'h0, 32'h0};
      tbl[7]  = '{1'b0, 3'd7, 32'h0, 32'h0};
      tbl[8]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'hF};
      tbl[9]  = '{1'b1, 3'd4, 32'h0000_0005, 32'h5};
      tbl[10] = '{1'b1, 3'd5, 32'hFFFF_FFFA, 32'hA};
      tbl[11] = '{1'b1, 3'd6, 32'hFFFF_1234, 32'h1234};
      tbl[12] = '{1'b1, 3'd7, 32'h0000_0055, 32'h0};
      tbl[13] = '{1'b1, 3'd0, 32'h0000_000F, 32'h0};
      tbl[14] = '{1'b1, 3'd1, 32'h0000_000F, 32'h0};
      tbl[15] = '{1'b1, 3'd2, 32'h0, 32'h0};
      tbl[16] = '{1'b1, 3'd4, 32'hF, 32'hF};
      tbl[17] = '{1'b1, 3'd5, 32'hF, 32'hF};
      tbl[18] = '{1'b1, 3'd6, 32'h0, 32'h0};

      step(2);
      check("reset_readdata", readdata, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      reset_n = 1;
      step(1);
      for (int i = 0; i < 19; i++) begin
         if (tbl[i].wr) bus_write(tbl[i].a, tbl[i].wd);
         bus_read(tbl[i].a, rd);
         check($sformatf("vec%0d_addr%0d", i, tbl[i].a), rd, tbl[i].exp);
      end
      check("idle_irq", {31'b0, irq}, 32'h0);

      // N=0: DATA after edge 3, capture/irq at edge 4
      bus_write(2, 32'h1);
      in_port = 4'h1;
      step(3);
      check("n0_irq_e3", {31'b0, irq}, 32'h0);
      check("n0_data_e3", readdata, 32'h0);
      step(1);
      check("n0_irq_e4", {31'b0, irq}, 32'h1);
      check("n0_data_e4", readdata, 32'h1);
      bus_read(3, rd); check("n0_capture", rd, 32'h1);
      bus_read(1, rd); check("n0_raw", rd, 32'h1);
      bus_write(3, 32'h1);
      check("n0_irq_cleared", {31'b0, irq}, 32'h0);
      bus_read(3, rd); check("n0_capture_cleared", rd, 32'h0);
      in_port = 4'h0;
      step(8);
      bus_write(3, 32'hF);
      bus_write(2, 32'h0);

      // N=5: a 4-cycle glitch is rejected, RAW still shows it
      bus_write(6, 32'd5);
      bus_write(2, 32'h4);
      in_port = 4'h4; address = 1;
      step(4);
      check("glitch_raw", readdata, 32'h4);
      in_port = 4'h0; address = 0;
      step(12);
      check("glitch_data", readdata, 32'h0);
      bus_read(3, rd); check("glitch_capture", rd, 32'h0);
      check("glitch_irq", {31'b0, irq}, 32'h0);

      // N=5: stable change accepted at edge 7, captured at edge 8
      in_port = 4'h4;
      step(7);
      check("n5_data_e7", readdata, 32'h0);
      check("n5_irq_e7", {31'b0, irq}, 32'h0);
      step(1);
      check("n5_data_e8", readdata, 32'h4);
      check("n5_irq_e8", {31'b0, irq}, 32'h1);
      in_port = 4'h0;
      step(12);
      bus_write(3, 32'hF);
      check("n5_irq_cleared", {31'b0, irq}, 32'h0);

      // N rewritten to 2 while cnt counts up: accept at edge 6 instead of 7
      in_port = 4'h4;
      step(4);
      bus_write(6, 32'd2);
      step(1);
      check("rewrite_data_e6", readdata, 32'h0);
      check("rewrite_irq_e6", {31'b0, irq}, 32'h0);
      step(1);
      check("rewrite_data_e7", readdata, 32'h4);
      check("rewrite_irq_e7", {31'b0, irq}, 32'h1);
      in_port = 4'h0;
      bus_write(6, 32'd0);
      step(6);
      bus_write(3, 32'hF);
      bus_write(2, 32'h0);

      // Falling-only capture on bit 1
      bus_write(4, 32'h0);
      bus_write(5, 32'h2);
      in_port = 4'h2;
      step(8);
      bus_read(3, rd); check("fall_only_after_rise", rd, 32'h0);
      in_port = 4'h0;
      step(8);
      bus_read(3, rd); check("fall_only_after_fall", rd, 32'h2);
      bus_write(4, 32'hF);
      bus_write(5, 32'hF);
      bus_write(3, 32'hF);

      // Edge on bit 3 coincides with a clear of bit 3: set wins
      in_port = 4'h8;
      step(3);
      bus_write(3, 32'h8);
      bus_read(3, rd); check("set_beats_clear", rd, 32'h8);
      bus_write(3, 32'h8);
      bus_read(3, rd); check("later_clear", rd, 32'h0);

      // Reset mid-debounce with capture=0xF, mask=0xF
      in_port = 4'h7;
      step(6);
      bus_read(3, rd); check("pre_reset_capture", rd, 32'hF);
      bus_write(2, 32'hF);
      check("pre_reset_irq", {31'b0, irq}, 32'h1);
      bus_write(6, 32'd5);
      in_port = 4'h1;
      step(4);
      reset_n = 0;
      #1;
      check("reset_irq_async", {31'b0, irq}, 32'h0);
      check("reset_readdata_async", readdata, 32'h0);
      step(1);
      address = 3;
      reset_n = 1;
      step(4);
      check("post_reset_cap_e4", readdata, 32'h0);
      step(1);
      check("post_reset_cap_e5", readdata, 32'h1);
      address = 0;
      bus_read(2, rd); check("post_reset_mask", rd, 32'h0);
      bus_read(6, rd); check("post_reset_thresh", rd, 32'h0);
      bus_read(4, rd); check("post_reset_rise_en", rd, 32'hF);
      bus_read(5, rd); check("post_reset_fall_en", rd, 32'hF);
      bus_read(0, rd); check("post_reset_data", rd, 32'h1);
      bus_read(1, rd); check("post_reset_raw", rd, 32'h1);
      check("post_reset_irq", {31'b0, irq}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
